// File: rtl/rtc_bus_scheduler_if.sv
// Bundle of every non-clock, non-reset signal of the RTC bus scheduler.
// master: the scheduler itself (drives acks, timing commands, AD bus, read results).
// slave : the requesters, the strobe-timing generator and the AD bus pins.
//   i_*      init sequencer write request / ack
//   w_*      user register write request / ack
//   rd_now   immediate read-burst request
//   tim_*    timing generator commands and phase-complete strobe
//   bus_*    multiplexed AD bus drive, enable and read-back
//   rd_*     captured read byte, index and strobes
//   busy, timeout_err  status
interface rtc_bus_scheduler_if;
  logic       i_req;
  logic [7:0] i_addr;
  logic [7:0] i_data;
  logic       i_ack;
  logic       w_req;
  logic [7:0] w_addr;
  logic [7:0] w_data;
  logic       w_ack;
  logic       rd_now;
  logic       tim_dir;
  logic       tim_wr;
  logic       tim_rd;
  logic       tim_done;
  logic [7:0] bus_dout;
  logic       bus_oe;
  logic [7:0] bus_din;
  logic [7:0] rd_data;
  logic [3:0] rd_idx;
  logic       rd_valid;
  logic       burst_done;
  logic       busy;
  logic       timeout_err;

  modport master (
    input  i_req, i_addr, i_data, w_req, w_addr, w_data, rd_now, tim_done, bus_din,
    output i_ack, w_ack, tim_dir, tim_wr, tim_rd, bus_dout, bus_oe,
           rd_data, rd_idx, rd_valid, burst_done, busy, timeout_err
  );

  modport slave (
    output i_req, i_addr, i_data, w_req, w_addr, w_data, rd_now, tim_done, bus_din,
    input  i_ack, w_ack, tim_dir, tim_wr, tim_rd, bus_dout, bus_oe,
           rd_data, rd_idx, rd_valid, burst_done, busy, timeout_err
  );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// Single owner of the multiplexed RTC address/data bus. Arbitrates between the init
// sequencer, user writes and periodic/immediate time-register read bursts, and runs each
// transaction as address phase -> data phase -> one-cycle ack.
// Ports:
//   Clk  system clock
//   Rst  synchronous reset, active-low
//   sif  scheduler side (master modport) of rtc_bus_scheduler_if
module rtc_bus_scheduler #(
  parameter int unsigned REFRESH_CYC = 1000000,
  parameter logic [7:0]  RD_BASE     = 8'h21,
  parameter int unsigned RD_COUNT    = 9,
  parameter int unsigned TO_CYC      = 255
) (
  input logic                 Clk,
  input logic                 Rst,
  rtc_bus_scheduler_if.master sif
);

  localparam int unsigned RefW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam int unsigned WdW  = $clog2(TO_CYC + 1);

  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_CYC - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TO_CYC - 1);
  localparam logic [3:0]      IdxLast = 4'(RD_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StAck} state_e;
  typedef enum logic [1:0] {SrcInit, SrcUser, SrcRead} src_e;

  state_e          state_q, state_d;
  src_e            src_q, src_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [3:0]      idx_q, idx_d;
  logic            rd_pend_q, rd_pend_d;
  logic [RefW-1:0] refresh_q, refresh_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic            tmo_q, tmo_d;          // current transaction timed out
  logic            timeout_err_q, timeout_err_d;
  logic [7:0]      rd_data_q, rd_data_d;
  // Acks of the previous cycle; a source is ineligible in the IDLE cycle after its ack.
  logic            ack_i_q, ack_w_q, ack_r_q;

  logic       i_ack_c, w_ack_c, rd_ack_c;
  logic       tim_dir_c, tim_wr_c, tim_rd_c, bus_oe_c;
  logic [7:0] bus_dout_c;
  logic [3:0] rd_idx_c;
  logic       rd_valid_c, burst_done_c;
  logic       refresh_wrap, rd_set, rd_clr;

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    addr_d        = addr_q;
    data_d        = data_q;
    idx_d         = idx_q;
    wdog_d        = wdog_q;
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q;
    rd_data_d     = rd_data_q;
    i_ack_c       = 1'b0;
    w_ack_c       = 1'b0;
    rd_ack_c      = 1'b0;
    tim_dir_c     = 1'b0;
    tim_wr_c      = 1'b0;
    tim_rd_c      = 1'b0;
    bus_oe_c      = 1'b0;
    bus_dout_c    = 8'h00;
    rd_idx_c      = 4'h0;
    rd_valid_c    = 1'b0;
    burst_done_c  = 1'b0;
    rd_clr        = 1'b0;

    refresh_wrap = (refresh_q == RefLast);
    refresh_d    = refresh_wrap ? '0 : refresh_q + RefW'(1);
    rd_set       = refresh_wrap | sif.rd_now;

    unique case (state_q)
      StIdle: begin
        wdog_d = '0;
        tmo_d  = 1'b0;
        if (sif.i_req && !ack_i_q) begin
          src_d   = SrcInit;
          addr_d  = sif.i_addr;
          data_d  = sif.i_data;
          state_d = StAddr;
        end else if (sif.w_req && !ack_w_q) begin
          src_d   = SrcUser;
          addr_d  = sif.w_addr;
          data_d  = sif.w_data;
          state_d = StAddr;
        end else if (rd_pend_q && !ack_r_q) begin
          src_d   = SrcRead;
          addr_d  = RD_BASE + {4'h0, idx_q};
          data_d  = 8'h00;
          state_d = StAddr;
        end
      end

      StAddr: begin
        tim_dir_c  = 1'b1;
        bus_oe_c   = 1'b1;
        bus_dout_c = addr_q;
        if (sif.tim_done) begin
          state_d = StData;
          wdog_d  = '0;
        end else if (wdog_q == WdLast) begin
          state_d       = StAck;
          tmo_d         = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end

      StData: begin
        if (src_q == SrcRead) begin
          tim_rd_c = 1'b1;
        end else begin
          tim_wr_c   = 1'b1;
          bus_oe_c   = 1'b1;
          bus_dout_c = data_q;
        end
        if (sif.tim_done) begin
          state_d = StAck;
          if (src_q == SrcRead) rd_data_d = sif.bus_din;
        end else if (wdog_q == WdLast) begin
          state_d       = StAck;
          tmo_d         = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end

      StAck: begin
        state_d = StIdle;
        i_ack_c = (src_q == SrcInit);
        w_ack_c = (src_q == SrcUser);
        if (src_q == SrcRead) begin
          rd_ack_c = 1'b1;
          if (tmo_q) begin
            // Abort the burst; the next one starts from the first register.
            idx_d  = 4'h0;
            rd_clr = 1'b1;
          end else begin
            rd_valid_c = 1'b1;
            rd_idx_c   = idx_q;
            if (idx_q == IdxLast) begin
              burst_done_c = 1'b1;
              idx_d        = 4'h0;
              rd_clr       = 1'b1;
            end else begin
              idx_d = idx_q + 4'h1;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // A set coinciding with the burst-final clear wins so another burst follows.
    if (rd_set) begin
      rd_pend_d = 1'b1;
    end else if (rd_clr) begin
      rd_pend_d = 1'b0;
    end else begin
      rd_pend_d = rd_pend_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q       <= StIdle;
      src_q         <= SrcInit;
      addr_q        <= 8'h00;
      data_q        <= 8'h00;
      idx_q         <= 4'h0;
      rd_pend_q     <= 1'b0;
      refresh_q     <= '0;
      wdog_q        <= '0;
      tmo_q         <= 1'b0;
      timeout_err_q <= 1'b0;
      rd_data_q     <= 8'h00;
      ack_i_q       <= 1'b0;
      ack_w_q       <= 1'b0;
      ack_r_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      idx_q         <= idx_d;
      rd_pend_q     <= rd_pend_d;
      refresh_q     <= refresh_d;
      wdog_q        <= wdog_d;
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
      rd_data_q     <= rd_data_d;
      ack_i_q       <= i_ack_c;
      ack_w_q       <= w_ack_c;
      ack_r_q       <= rd_ack_c;
    end
  end

  assign sif.i_ack       = i_ack_c;
  assign sif.w_ack       = w_ack_c;
  assign sif.tim_dir     = tim_dir_c;
  assign sif.tim_wr      = tim_wr_c;
  assign sif.tim_rd      = tim_rd_c;
  assign sif.bus_dout    = bus_dout_c;
  assign sif.bus_oe      = bus_oe_c;
  assign sif.rd_data     = rd_data_q;
  assign sif.rd_idx      = rd_idx_c;
  assign sif.rd_valid    = rd_valid_c;
  assign sif.burst_done  = burst_done_c;
  assign sif.busy        = (state_q != StIdle);
  assign sif.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Self-checking bench for rtc_bus_scheduler: table-driven write vectors plus directed
// sequences for arbitration, bursts, interleave, timeout, reset and refresh.
module tb_rtc_bus_scheduler;

  localparam int unsigned RefCyc = 3000;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  rtc_bus_scheduler_if sif ();

  rtc_bus_scheduler #(
    .REFRESH_CYC(RefCyc),
    .RD_BASE    (8'h21),
    .RD_COUNT   (9),
    .TO_CYC     (255)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .sif(sif)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  // Monitor state (sampled on the falling edge).
  int         cyc = 0;
  logic [7:0] addr_log[$];
  logic [7:0] wdat_log[$];
  logic [3:0] rdi_log[$];
  logic [7:0] rdd_log[$];
  int         n_iack = 0, n_wack = 0, iack_cyc = 0, wack_cyc = 0, last_done_cyc = 0;
  int         n_bdone = 0;
  logic [3:0] bdone_idx = 4'h0;
  logic       bdone_valid = 1'b0;
  logic [7:0] cur_addr = 8'h00;
  bit         prev_dir = 0, prev_wr = 0, prev_rd = 0;

  // Timing-generator model: tim_done three cycles after each command starts.
  bit         hold_en = 0;
  logic [7:0] hold_addr = 8'h00;
  int         rcnt = 0;

  initial begin
    sif.tim_done = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      if ((sif.tim_dir || sif.tim_wr || sif.tim_rd) &&
          !(hold_en && sif.tim_rd && cur_addr == hold_addr)) begin
        if (rcnt == 2) begin
          sif.tim_done = 1'b1;
          rcnt = 0;
        end else begin
          sif.tim_done = 1'b0;
          rcnt++;
        end
      end else begin
        sif.tim_done = 1'b0;
        rcnt = 0;
      end
    end
  end

  initial begin
    sif.bus_din = 8'h00;
    forever begin
      @(negedge Clk);
      cyc++;
      if (sif.tim_done) last_done_cyc = cyc;
      if (sif.tim_dir && !prev_dir) begin
        addr_log.push_back(sif.bus_dout);
        cur_addr = sif.bus_dout;
        // Register at RD_BASE+i returns 8'h30+i.
        sif.bus_din = 8'h30 + (sif.bus_dout - 8'h21);
        chk("addr_oe", {31'd0, sif.bus_oe}, 32'd1);
      end
      if (sif.tim_wr && !prev_wr) begin
        wdat_log.push_back(sif.bus_dout);
        chk("wdat_oe", {31'd0, sif.bus_oe}, 32'd1);
      end
      if (sif.tim_rd && !prev_rd) chk("rd_oe", {31'd0, sif.bus_oe}, 32'd0);
      if (sif.rd_valid) begin
        rdi_log.push_back(sif.rd_idx);
        rdd_log.push_back(sif.rd_data);
      end
      if (sif.i_ack) begin
        n_iack++;
        iack_cyc = cyc;
      end
      if (sif.w_ack) begin
        n_wack++;
        wack_cyc = cyc;
      end
      if (sif.burst_done) begin
        n_bdone++;
        bdone_idx   = sif.rd_idx;
        bdone_valid = sif.rd_valid;
      end
      prev_dir = sif.tim_dir;
      prev_wr  = sif.tim_wr;
      prev_rd  = sif.tim_rd;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    bit         init;
    logic [7:0] addr;
    logic [7:0] data;
    int         exp_lat;   // request tick -> ack tick
  } wvec_t;

  task automatic clear_logs();
    addr_log.delete();
    wdat_log.delete();
    rdi_log.delete();
    rdd_log.delete();
  endtask

  task automatic wait_bdone(input string nm, input int target, input int bound);
    bit got = 0;
    for (int t = 0; t < bound && !got; t++) begin
      tick();
      if (n_bdone >= target) got = 1;
    end
    chk(nm, {31'd0, got}, 32'd1);
  endtask

  initial begin
    wvec_t      wv[5];
    logic [7:0] exp_addr[$];
    bit         got, got_i, got_w, w_raised, rn_sent;
    int         lat, a1, ni0, nw0, nb0, t0, ln, dt;
    logic [31:0] acc;

    wv[0] = '{1'b1, 8'h02, 8'h10, 7};
    wv[1] = '{1'b0, 8'h5a, 8'ha5, 7};
    wv[2] = '{1'b1, 8'hff, 8'h00, 7};
    wv[3] = '{1'b0, 8'h00, 8'hff, 7};
    wv[4] = '{1'b0, 8'h7e, 8'h81, 7};

    Rst = 1'b0;
    sif.i_req = 1'b0; sif.i_addr = 8'h00; sif.i_data = 8'h00;
    sif.w_req = 1'b0; sif.w_addr = 8'h00; sif.w_data = 8'h00;
    sif.rd_now = 1'b0;
    repeat (3) tick();
    Rst = 1'b1;

    // Idle after reset: every output stays 0.
    acc = 32'd0;
    for (int t = 0; t < 20; t++) begin
      tick();
      acc |= {sif.i_ack, sif.w_ack, sif.tim_dir, sif.tim_wr, sif.tim_rd, sif.bus_oe,
              sif.rd_valid, sif.burst_done, sif.busy, sif.timeout_err, sif.rd_idx};
      acc |= {16'd0, sif.bus_dout, sif.rd_data};
    end
    chk("reset_outputs", acc, 32'd0);
    chk("reset_busy", {31'd0, sif.busy}, 32'd0);

    // Table-driven single writes.
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      ni0 = n_iack;
      nw0 = n_wack;
      if (wv[v].init) begin
        sif.i_req = 1'b1; sif.i_addr = wv[v].addr; sif.i_data = wv[v].data;
      end else begin
        sif.w_req = 1'b1; sif.w_addr = wv[v].addr; sif.w_data = wv[v].data;
      end
      got = 0;
      lat = 0;
      for (int t = 1; t <= 50 && !got; t++) begin
        tick();
        if ((wv[v].init && sif.i_ack) || (!wv[v].init && sif.w_ack)) begin
          got = 1;
          lat = t;
        end
      end
      sif.i_req = 1'b0;
      sif.w_req = 1'b0;
      chk("wr_ack_seen", {31'd0, got}, 32'd1);
      chk("wr_latency", lat, wv[v].exp_lat);
      chk("wr_addr", {24'd0, addr_log[0]}, {24'd0, wv[v].addr});
      chk("wr_data", {24'd0, wdat_log[0]}, {24'd0, wv[v].data});
      chk("wr_ack_after_done",
          (wv[v].init ? iack_cyc : wack_cyc) - last_done_cyc, 32'd1);
      chk("wr_other_ack", wv[v].init ? n_wack - nw0 : n_iack - ni0, 32'd0);
      repeat (4) tick();
    end

    // Held init request: second grant skips the IDLE cycle right after the ack.
    sif.i_req = 1'b1; sif.i_addr = 8'h40; sif.i_data = 8'h41;
    ni0 = n_iack;
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      tick();
      if (sif.i_ack) got = 1;
    end
    a1 = iack_cyc;
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      tick();
      if (sif.i_ack) got = 1;
    end
    sif.i_req = 1'b0;
    chk("b2b_second_ack", {31'd0, got}, 32'd1);
    chk("b2b_ack_gap", iack_cyc - a1, 32'd9);
    repeat (5) tick();

    // Simultaneous init and user requests.
    clear_logs();
    ni0 = n_iack;
    nw0 = n_wack;
    sif.i_req = 1'b1; sif.i_addr = 8'h11; sif.i_data = 8'h12;
    sif.w_req = 1'b1; sif.w_addr = 8'h22; sif.w_data = 8'h23;
    got_i = 0;
    got_w = 0;
    for (int t = 0; t < 80 && !(got_i && got_w); t++) begin
      tick();
      if (sif.i_ack) begin got_i = 1; sif.i_req = 1'b0; end
      if (sif.w_ack) begin got_w = 1; sif.w_req = 1'b0; end
    end
    sif.i_req = 1'b0;
    sif.w_req = 1'b0;
    repeat (20) tick();
    chk("dual_iack_cnt", n_iack - ni0, 32'd1);
    chk("dual_wack_cnt", n_wack - nw0, 32'd1);
    chk("dual_order", {31'd0, iack_cyc < wack_cyc}, 32'd1);
    chk("dual_first_addr", {24'd0, addr_log[0]}, 32'h11);
    chk("dual_second_addr", {24'd0, addr_log[1]}, 32'h22);

    // Read burst; the second rd_now pulse arrives while already pending.
    clear_logs();
    nb0 = n_bdone;
    sif.rd_now = 1'b1;
    tick();
    tick();
    sif.rd_now = 1'b0;
    wait_bdone("burst_done_seen", nb0 + 1, 400);
    repeat (30) tick();
    chk("burst_no_requeue", n_bdone - nb0, 32'd1);
    chk("burst_reads", rdi_log.size(), 32'd9);
    chk("burst_idle", {31'd0, sif.busy}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      chk("burst_idx", {28'd0, rdi_log[i]}, i);
      chk("burst_data", {24'd0, rdd_log[i]}, 32'h30 + i);
      chk("burst_addr", {24'd0, addr_log[i]}, 32'h21 + i);
    end
    chk("burst_done_idx", {28'd0, bdone_idx}, 32'd8);
    chk("burst_done_valid", {31'd0, bdone_valid}, 32'd1);

    // Write inserted after idx 3; rd_now in the final ack cycle starts a new burst.
    clear_logs();
    nb0 = n_bdone;
    nw0 = n_wack;
    w_raised = 0;
    rn_sent = 0;
    sif.rd_now = 1'b1;
    tick();
    sif.rd_now = 1'b0;
    for (int t = 0; t < 800 && (n_bdone - nb0) < 2; t++) begin
      tick();
      sif.rd_now = 1'b0;
      if (!w_raised && rdi_log.size() == 4) begin
        w_raised = 1;
        sif.w_req = 1'b1; sif.w_addr = 8'h55; sif.w_data = 8'h66;
      end
      if (sif.w_ack) sif.w_req = 1'b0;
      if (!rn_sent && (n_bdone - nb0) == 1) begin
        rn_sent = 1;
        sif.rd_now = 1'b1;
      end
    end
    sif.rd_now = 1'b0;
    sif.w_req = 1'b0;
    chk("ilv_two_bursts", n_bdone - nb0, 32'd2);
    chk("ilv_wack", n_wack - nw0, 32'd1);
    chk("ilv_wdata", {24'd0, wdat_log[0]}, 32'h66);
    exp_addr.delete();
    for (int i = 0; i < 4; i++) exp_addr.push_back(8'h21 + 8'(i));
    exp_addr.push_back(8'h55);
    for (int i = 4; i < 9; i++) exp_addr.push_back(8'h21 + 8'(i));
    for (int i = 0; i < 9; i++) exp_addr.push_back(8'h21 + 8'(i));
    chk("ilv_addr_count", addr_log.size(), exp_addr.size());
    for (int i = 0; i < 19; i++) chk("ilv_addr", {24'd0, addr_log[i]}, {24'd0, exp_addr[i]});
    chk("ilv_reads", rdi_log.size(), 32'd18);
    for (int i = 0; i < 18; i++) begin
      chk("ilv_idx", {28'd0, rdi_log[i]}, i % 9);
      chk("ilv_data", {24'd0, rdd_log[i]}, 32'h30 + (i % 9));
    end
    repeat (10) tick();

    // Timeout in the read data phase at idx 2.
    clear_logs();
    nb0 = n_bdone;
    hold_en = 1;
    hold_addr = 8'h23;
    sif.rd_now = 1'b1;
    tick();
    sif.rd_now = 1'b0;
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      tick();
      if (sif.tim_rd && cur_addr == 8'h23) got = 1;
    end
    chk("tmo_reach_phase", {31'd0, got}, 32'd1);
    repeat (253) tick();
    chk("tmo_not_early_rd", {31'd0, sif.tim_rd}, 32'd1);
    chk("tmo_not_early_err", {31'd0, sif.timeout_err}, 32'd0);
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      tick();
      if (!sif.busy) got = 1;
    end
    chk("tmo_back_idle", {31'd0, got}, 32'd1);
    chk("tmo_err", {31'd0, sif.timeout_err}, 32'd1);
    chk("tmo_reads", rdi_log.size(), 32'd2);
    chk("tmo_no_bdone", n_bdone - nb0, 32'd0);
    hold_en = 0;
    repeat (40) tick();
    chk("tmo_aborted", addr_log.size(), 32'd3);
    chk("tmo_err_sticky", {31'd0, sif.timeout_err}, 32'd1);
    sif.rd_now = 1'b1;
    tick();
    sif.rd_now = 1'b0;
    wait_bdone("tmo_rerun_done", nb0 + 1, 400);
    chk("tmo_restart_addr", {24'd0, addr_log[3]}, 32'h21);
    chk("tmo_rerun_reads", rdi_log.size(), 32'd11);
    Rst = 1'b0;
    tick();
    chk("tmo_reset_clear", {31'd0, sif.timeout_err}, 32'd0);
    Rst = 1'b1;
    repeat (5) tick();

    // Reset during the address phase releases the bus at once.
    sif.i_req = 1'b1; sif.i_addr = 8'h33; sif.i_data = 8'h34;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      if (sif.tim_dir) got = 1;
    end
    chk("rst_mid_reach", {31'd0, got}, 32'd1);
    Rst = 1'b0;
    tick();
    chk("rst_mid_bus", {29'd0, sif.busy, sif.bus_oe, sif.tim_dir}, 32'd0);
    sif.i_req = 1'b0;
    Rst = 1'b1;

    // Automatic refresh burst after REFRESH_CYC cycles of the timer.
    clear_logs();
    nb0 = n_bdone;
    t0 = cyc;
    ln = 0;
    got = 0;
    for (int t = 0; t < int'(RefCyc) + 100 && !got; t++) begin
      tick();
      if (addr_log.size() > 0) got = 1;
    end
    dt = cyc - t0;
    chk("refresh_started", {31'd0, got}, 32'd1);
    chk("refresh_addr", {24'd0, addr_log[0]}, 32'h21);
    chk("refresh_window", {31'd0, (dt >= int'(RefCyc) - 3) && (dt <= int'(RefCyc) + 3)},
        32'd1);
    wait_bdone("refresh_done", nb0 + 1, 400);
    ln = rdi_log.size();
    chk("refresh_reads", ln, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
